// File: rtl/vc_plane_controller_pkg.sv
// Shared NoC constants for the VC plane controller and the node/router wrappers.
package vc_plane_controller_pkg;

  // Default number of virtual-channel planes sharing one physical link.
  localparam int unsigned VC_DEFAULT = 4;

  // Selector width: one bit wider than VC so node and router ports line up.
  localparam int unsigned VC_SEL_W = VC_DEFAULT + 1;

  // Selector width for an arbitrary plane count.
  function automatic int unsigned vc_sel_width(input int unsigned vc);
    return vc + 1;
  endfunction

endpackage

// File: rtl/vc_rr_next.sv
// Finds the first requesting plane after the current one, in circular order.
module vc_rr_next
  import vc_plane_controller_pkg::*;
#(
  parameter int unsigned VC = VC_DEFAULT
) (
  input  logic [VC:0]   i_sel,
  input  logic [VC-1:0] i_req,
  output logic [VC:0]   o_next,
  output logic          o_any
);

  localparam int unsigned SW = vc_sel_width(VC);
  localparam int unsigned IW = (VC > 1) ? $clog2(VC) : 1;

  logic [IW-1:0] w_idx;

  // Scan (sel+1) .. (sel+VC) mod VC; the first requester wins.
  always_comb begin
    o_next = '0;
    o_any  = 1'b0;
    w_idx  = '0;
    for (int k = 1; k <= int'(VC); k++) begin
      w_idx = IW'((32'(i_sel) + 32'(k)) % VC);
      if (!o_any && i_req[w_idx]) begin
        o_next = SW'(w_idx);
        o_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_plane_controller.sv
// Time-multiplexes VC virtual-channel planes onto one link by rotating a plane index.
// Optional feature macro: VC_PLANE_SKIP_EN (skip idle planes, plane 0 starvation guard).
module vc_plane_controller
  import vc_plane_controller_pkg::*;
#(
  parameter int unsigned VC = VC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [VC-1:0] plane_req,
  output logic [VC:0]   VCPlaneSelectorVerifier,
  output logic [VC:0]   VCPlaneSelectorRouter,
  output logic [VC-1:0] VCPlaneOneHot,
  output logic          plane_wrap
);

  localparam int unsigned SW = vc_sel_width(VC);

  logic [SW-1:0] r_sel;
  logic [SW-1:0] w_sel_inc;
  logic [SW-1:0] w_sel_next;

  // Plain +1 rotation with wrap at VC-1.
  always_comb begin
    w_sel_inc = (r_sel == SW'(VC - 1)) ? '0 : r_sel + SW'(1);
  end

`ifdef VC_PLANE_SKIP_EN
  localparam int unsigned AW = (VC > 1) ? $clog2(VC) : 1;

  logic [AW-1:0] r_since0;
  logic [SW-1:0] w_rr_next;
  logic          w_rr_any;
  logic          w_starve;

  vc_rr_next #(
    .VC(VC)
  ) u_rr_next (
    .i_sel (r_sel),
    .i_req (plane_req),
    .o_next(w_rr_next),
    .o_any (w_rr_any)
  );

  // Plane 0 is forced once it has been absent for VC-1 cycles, so it recurs within VC.
  always_comb begin
    w_starve   = plane_req[0] && (r_since0 == AW'(VC - 1));
    w_sel_next = w_sel_inc;
    if (w_starve) begin
      w_sel_next = '0;
    end else if (w_rr_any) begin
      w_sel_next = w_rr_next;
    end
  end

  // Cycles since plane 0 was last active, saturating at VC-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_since0 <= '0;
    end else if (w_sel_next == '0) begin
      r_since0 <= '0;
    end else if (r_since0 != AW'(VC - 1)) begin
      r_since0 <= r_since0 + AW'(1);
    end
  end
`else
  logic w_unused_req;

  // Requests have no effect on the fixed rotation.
  assign w_unused_req = ^plane_req;

  // Fixed rotation: advance every cycle.
  always_comb begin
    w_sel_next = w_sel_inc;
  end
`endif

  // Active plane index register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel <= '0;
    end else begin
      r_sel <= w_sel_next;
    end
  end

  // Both link ends see the same index with no added latency.
  assign VCPlaneSelectorVerifier = r_sel;
  assign VCPlaneSelectorRouter   = r_sel;

  // One-hot decode of the active plane.
  always_comb begin
    VCPlaneOneHot = '0;
    for (int p = 0; p < int'(VC); p++) begin
      VCPlaneOneHot[p] = (r_sel == SW'(p));
    end
  end

  // Last plane of the rotation.
  assign plane_wrap = (r_sel == SW'(VC - 1));

endmodule

// File: tb/tb_vc_plane_controller.sv
// Scoreboard bench for vc_plane_controller (VC=4).
module tb_vc_plane_controller;

  localparam int unsigned VC = 4;
  localparam int unsigned SW = VC + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [VC-1:0] plane_req = '0;
  logic [VC:0]   sel_ver;
  logic [VC:0]   sel_rtr;
  logic [VC-1:0] one_hot;
  logic          wrap;

  typedef struct {
    logic [SW-1:0] sel;
    logic [VC-1:0] oh;
    logic          wrap;
    string         name;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  event mid_sample;

  vc_plane_controller #(
    .VC(VC)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .plane_req              (plane_req),
    .VCPlaneSelectorVerifier(sel_ver),
    .VCPlaneSelectorRouter  (sel_rtr),
    .VCPlaneOneHot          (one_hot),
    .plane_wrap             (wrap)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [SW-1:0] s, input logic w, input string nm);
    exp_t e;
    e.sel  = s;
    e.oh   = VC'(1) << s;
    e.wrap = w;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; sample on the falling edge or on demand.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or mid_sample);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (sel_ver !== e.sel || sel_rtr !== e.sel || one_hot !== e.oh || wrap !== e.wrap) begin
          errors++;
          $display("FAIL %s: got ver=%0d rtr=%0d oh=%b wrap=%b, want sel=%0d oh=%b wrap=%b",
                   e.name, sel_ver, sel_rtr, one_hot, wrap, e.sel, e.oh, e.wrap);
        end
        checks++;
        if (sel_ver !== sel_rtr || sel_ver >= SW'(VC) || $countones(one_hot) != 1) begin
          errors++;
          $display("FAIL invariant(%s): got ver=%0d rtr=%0d popcount=%0d, want equal, <%0d, popcount 1",
                   e.name, sel_ver, sel_rtr, $countones(one_hot), VC);
        end
      end
    end
  end

  // Stimulus: pushes the hand-derived expected value for each cycle it drives.
  initial begin
    logic [SW-1:0] rot_sel[10];
    logic          rot_wrap[10];
    logic [SW-1:0] s;
    rot_sel  = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd1};
    rot_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset held low across three edges.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      push_exp(5'd0, 1'b0, $sformatf("reset%0d", i));
    end

`ifndef VC_PLANE_SKIP_EN
    // Release and rotate for 10 cycles.
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_exp(rot_sel[0], rot_wrap[0], "rot0");
    for (int i = 1; i < 10; i++) begin
      @(posedge clk);
      #1;
      push_exp(rot_sel[i], rot_wrap[i], $sformatf("rot%0d", i));
    end

    // Mid-rotation reset while sel=2.
    @(posedge clk);
    #1;
    push_exp(5'd2, 1'b0, "pre_mid");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    push_exp(5'd0, 1'b0, "mid_rst");
    -> mid_sample;
    @(posedge clk);
    #1;
    push_exp(5'd0, 1'b0, "rst_hold");
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_exp(5'd1, 1'b0, "post_rel");

    // Long run with random, ignored requests.
    s = 5'd1;
    for (int i = 0; i < 1000; i++) begin
      plane_req = VC'($urandom);
      @(posedge clk);
      #1;
      s = (s == SW'(VC - 1)) ? '0 : s + 5'd1;
      push_exp(s, s == SW'(VC - 1), "rand");
    end
`else
    // Skip mode: only planes 1 and 3 request.
    plane_req = 4'b1010;
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_exp(5'd0, 1'b0, "skip0");
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      push_exp((i % 2 == 0) ? 5'd1 : 5'd3, (i % 2 == 1), $sformatf("skip%0d", i + 1));
    end

    // Starvation guard: all request, plane 0 request toggling.
    begin
      int   since;
      logic req0_edge;
      since     = 0;
      plane_req = 4'b1111;
      for (int i = 0; i < 40; i++) begin
        req0_edge = plane_req[0];
        @(posedge clk);
        #1;
        since = (sel_ver == '0) ? 0 : since + 1;
        checks++;
        if (req0_edge && since > int'(VC) - 1) begin
          errors++;
          $display("FAIL starve%0d: got %0d cycles without plane 0, want at most %0d",
                   i, since, VC - 1);
        end
        plane_req[0] = ~plane_req[0];
      end
    end
`endif

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) begin
      @(negedge clk);
    end
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries pending, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
